// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width default and FSM encoding for the sequential divider
package seq_divider_pkg;
   localparam int DEF_WIDTH = 8;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring division iteration built on a ripple full-adder subtractor
module seq_divider_div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   r_sh,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] r_nxt,
   output logic             q_bit
);
   logic [WIDTH:0]   b;
   logic [WIDTH+1:0] c;
   logic [WIDTH-1:0] diff;
   // r_sh - divisor as r_sh + ~divisor + 1; carry out set means no borrow
   assign b    = ~{1'b0, divisor};
   assign c[0] = 1'b1;
   for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
      assign c[i+1] = (r_sh[i] & b[i]) | (c[i] & (r_sh[i] ^ b[i]));
   end
   // a successful subtraction always leaves a value below divisor, so the top bit is dropped
   assign diff  = r_sh[WIDTH-1:0] ^ b[WIDTH-1:0] ^ c[WIDTH-1:0];
   assign q_bit = c[WIDTH+1];
   assign r_nxt = q_bit ? diff : r_sh[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, 2W/W -> W quotient and W remainder
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               div_by_zero,
   output logic               overflow
);
   localparam int CW = $clog2(WIDTH);
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d, d_q, d_d, acc_q, acc_d, dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic             dbz_q, dbz_d, ovf_q, ovf_d;
   logic [WIDTH:0]   r_sh;
   logic [WIDTH-1:0] r_nxt;
   logic             q_bit;
   logic [WIDTH-1:0] hi, lo;
   assign hi   = dividend[2*WIDTH-1:WIDTH];
   assign lo   = dividend[WIDTH-1:0];
   assign r_sh = {r_q, d_q[WIDTH-1]};
   seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
      .r_sh    (r_sh),
      .divisor (dvs_q),
      .r_nxt   (r_nxt),
      .q_bit   (q_bit)
   );
   // next-state: operand capture and fast paths in IDLE, one iteration per CALC cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      d_d     = d_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (start) begin
            dbz_d = 1'b0;
            ovf_d = 1'b0;
            if (divisor == '0) begin
               quo_d   = '1;
               rem_d   = lo;
               dbz_d   = 1'b1;
               state_d = DONE;
            end else if (hi >= divisor) begin
               quo_d   = '1;
               rem_d   = '0;
               ovf_d   = 1'b1;
               state_d = DONE;
            end else begin
               r_d     = hi;
               d_d     = lo;
               dvs_d   = divisor;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            r_d   = r_nxt;
            d_d   = {d_q[WIDTH-2:0], 1'b0};
            acc_d = {acc_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               quo_d   = acc_d;
               rem_d   = r_nxt;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         d_q     <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         d_q     <= d_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy        = state_q == CALC;
   assign done        = state_q == DONE;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider, the inverse companion to the combinational 8x8 multiplier in the ALU. Divides a 2W-bit dividend by a W-bit divisor, producing a W-bit quotient and W-bit remainder in W iterations. Uses a start/busy/done handshake so the control unit can stall while a DIV/MOD instruction executes. Divide-by-zero and quotient overflow are flagged and take a one-cycle fast path.

## Interface
- WIDTH, 8, divisor, quotient and remainder width; dividend is 2*WIDTH bits
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- dividend  in  2*WIDTH  numerator, sampled with start
- divisor  in  WIDTH  denominator, sampled with start
- busy  out  1  high while in CALC
- done  out  1  one-cycle result-valid pulse
- quotient  out  WIDTH  registered result
- remainder  out  WIDTH  registered result
- div_by_zero  out  1  sticky until next accepted start
- overflow  out  1  quotient does not fit WIDTH bits; sticky until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start=1 accepts the operands and clears all flags:
  - divisor==0: go to DONE. quotient={W{1}}, remainder=dividend[W-1:0], div_by_zero=1.
  - Else, dividend[2W-1:W] >= divisor: go to DONE. quotient={W{1}}, remainder=0, overflow=1.
  - Else: go to CALC. Partial remainder R (W+1 bits) = dividend[2W-1:W]. Shift register D = dividend[W-1:0]. Iteration counter = 0.
- Each CALC cycle:
  - R' = {R[W-1:0], D[W-1]}; shift D left by 1.
  - If R' >= divisor: R = R' - divisor and shift 1 into the quotient LSB. Else: R = R' and shift 0 into the quotient LSB.
  - Counter increments. On the W-th iteration, go to DONE with quotient and remainder = R[W-1:0] registered.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start outside IDLE is ignored, including in DONE; there is no queueing.
- quotient, remainder and flags hold their values from DONE until the next accepted start. Intermediate quotient bits are held internally, so quotient never shows partial values.
- Width rule: R' is at most 2*divisor-1 and fits W+1 bits. The pre-check guarantees the final quotient fits W bits.

## Timing
- Accepting edge = E0.
- Normal division: busy high after E0 through the W-th CALC edge (E1..EW). done high for one cycle after EW, so latency is W+1 cycles from start to done. The next start can be accepted in the cycle after done, giving a minimum issue interval of W+2 cycles.
- Fast path (div_by_zero or overflow): busy stays 0. done is high in the cycle after E0.
- Reset (rst_n=0 at any edge): state=IDLE, counter=0, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
- Reset during CALC aborts the operation: no done is produced and the partial result is discarded.
- rst_n and start both active at the same edge: reset wins.

## Structure
- State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH go in the shared ALU definitions include, `alu_defs.v`. The multiplier and the future ALU decoder use the same file.
- One sub-module, `div_step`: a combinational single restoring iteration.
  - Inputs: R', divisor. Outputs: next R, quotient bit.
  - Implemented as a (W+1)-bit ripple subtractor built from the existing full-adder cell; the borrow-out selects restore.
- Top level holds the FSM, counter, D/R/quotient registers and output registers.

## Test plan
- 0x1234 / 0x56 -> after 9 cycles, done=1, quotient=0x36, remainder=0x10, both flags 0; busy high exactly 8 cycles.
- 0xFE01 / 0xFF -> quotient=0xFF, remainder=0x00, no flags (largest legal quotient).
- 0x00AB / 0x00 -> done in the cycle after start, div_by_zero=1, quotient=0xFF, remainder=0xAB, busy never high.
- 0x5000 / 0x50 -> done in the cycle after start, overflow=1, quotient=0xFF, remainder=0x00.
- Start 0x0007 / 0x03, pulse start again during CALC with other operands -> second start ignored; quotient=0x02, remainder=0x01; outputs hold until the next start.
- Start 0x1234 / 0x56, drive rst_n low at the 4th CALC edge -> all outputs 0, no done; then 0x0064 / 0x0A -> quotient=0x0A, remainder=0x00.
